// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit range limits and the load-value clamp helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MIN = 4'd0;
  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Invalid BCD nibbles (0xA-0xF) saturate to the largest legal digit
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit);
    bcd_digit_t result;
    if (digit > BCD_MAX) begin
      result = BCD_MAX;
    end else begin
      result = digit;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with ripple carry/borrow in and out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t value,
  output logic       cout
);

  bcd_digit_t value_r;
  bcd_digit_t next_s;
  logic       at_limit_s;

  // Limit detection for the current direction and the stepped digit value
  always_comb begin
    at_limit_s = 1'b0;
    next_s     = value_r;
    if (up) begin
      at_limit_s = (value_r == BCD_MAX);
      if (value_r == BCD_MAX) begin
        next_s = BCD_MIN;
      end else begin
        next_s = value_r + 4'd1;
      end
    end else begin
      at_limit_s = (value_r == BCD_MIN);
      if (value_r == BCD_MIN) begin
        next_s = BCD_MAX;
      end else begin
        next_s = value_r - 4'd1;
      end
    end
  end

  // Digit register: load has priority over stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= BCD_MIN;
    end else if (load) begin
      value_r <= bcd_clamp(load_digit);
    end else if (step && cin) begin
      value_r <= next_s;
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
  assign cout  = cin & at_limit_s;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with prescaler, synchronous load and
// wrap or saturate behaviour at the range limits.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int          DIGITS          = 4,
  parameter int unsigned CLOCKS_PER_TICK = 1,
  parameter bit          WRAP            = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  carry
);

  localparam logic [31:0] PRESC_TERM = 32'(CLOCKS_PER_TICK) - 32'd1;

  logic [31:0]   presc_r;
  logic          tick_r;
  logic          carry_r;
  logic          step_cycle_s;
  logic          hold_s;
  logic          digit_step_s;
  logic [DIGITS:0] chain_s;

  assign step_cycle_s = en & ~load & (presc_r == PRESC_TERM);
  // Saturating mode suppresses the digit update but still reports the step
  assign hold_s       = (WRAP == 1'b0) & chain_s[DIGITS];
  assign digit_step_s = step_cycle_s & ~hold_s;
  assign chain_s[0]   = 1'b1;

  // Prescaler phase: cleared by load, frozen while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= 32'd0;
    end else if (load) begin
      presc_r <= 32'd0;
    end else if (en) begin
      if (presc_r == PRESC_TERM) begin
        presc_r <= 32'd0;
      end else begin
        presc_r <= presc_r + 32'd1;
      end
    end else begin
      presc_r <= presc_r;
    end
  end

  // Step and whole-counter overflow/underflow pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r  <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      tick_r  <= step_cycle_s;
      carry_r <= step_cycle_s & chain_s[DIGITS];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .step       (digit_step_s),
      .up         (up),
      .cin        (chain_s[i]),
      .load       (load),
      .load_digit (load_value[4*i +: 4]),
      .value      (count[4*i +: 4]),
      .cout       (chain_s[i+1])
    );
  end

  assign tick  = tick_r;
  assign carry = carry_r;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream;
// expectations are queued per cycle and checked by an independent monitor.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;

  logic [15:0] count0, count1, count2;
  logic        tick0, tick1, tick2;
  logic        carry0, carry1, carry2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [15:0] cnt;
    logic        tk;
    logic        cy;
    string       name;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(4), .CLOCKS_PER_TICK(3), .WRAP(1'b1)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_value(load_value), .count(count0), .tick(tick0), .carry(carry0));

  bcd_updown_counter #(.DIGITS(4), .CLOCKS_PER_TICK(1), .WRAP(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_value(load_value), .count(count1), .tick(tick1), .carry(carry1));

  bcd_updown_counter #(.DIGITS(4), .CLOCKS_PER_TICK(1), .WRAP(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_value(load_value), .count(count2), .tick(tick2), .carry(carry2));

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic l, input logic [15:0] v);
    rst = r; en = e; up = u; load = l; load_value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int id, input logic [15:0] cnt,
                            input logic tk, input logic cy, input string name);
    exp_t e;
    e.id = id; e.cnt = cnt; e.tk = tk; e.cy = cy; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the selected instance
  initial begin
    exp_t e;
    logic [15:0] ac;
    logic at, ay;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.id)
          0:       begin ac = count0; at = tick0; ay = carry0; end
          1:       begin ac = count1; at = tick1; ay = carry1; end
          default: begin ac = count2; at = tick2; ay = carry2; end
        endcase
        checks++;
        if (ac !== e.cnt || at !== e.tk || ay !== e.cy) begin
          failures++;
          $display("FAIL %s (dut%0d): got count=%h tick=%b carry=%b, expected count=%h tick=%b carry=%b",
                   e.name, e.id, ac, at, ay, e.cnt, e.tk, e.cy);
        end
      end
    end
  end

  initial begin
    logic [15:0] exp_cnt;
    logic        exp_tk;
    // Reset state of all three configurations
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    expect_out(0, 16'h0000, 1'b0, 1'b0, "reset0");
    expect_out(1, 16'h0000, 1'b0, 1'b0, "reset1");
    expect_out(2, 16'h0000, 1'b0, 1'b0, "reset2");

    // Prescaler: steps on enabled edges 3, 6 and 9
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      exp_cnt = 16'(k / 3);
      exp_tk  = (k % 3 == 0);
      expect_out(0, exp_cnt, exp_tk, 1'b0, "prescaler");
    end

    // Cascade up/down and clamping
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0099); expect_out(1, 16'h0099, 1'b0, 1'b0, "load_0099");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(1, 16'h0100, 1'b1, 1'b0, "cascade_up");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0100); expect_out(1, 16'h0100, 1'b0, 1'b0, "load_0100");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); expect_out(1, 16'h0099, 1'b1, 1'b0, "cascade_down");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h00AF); expect_out(1, 16'h0099, 1'b0, 1'b0, "clamp_00af");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0042); expect_out(1, 16'h0042, 1'b0, 1'b0, "load_no_en");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000); expect_out(1, 16'h0042, 1'b0, 1'b0, "hold_no_en");

    // Wrap overflow/underflow
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h9999); expect_out(1, 16'h9999, 1'b0, 1'b0, "load_9999");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(1, 16'h0000, 1'b1, 1'b1, "wrap_over");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(1, 16'h0001, 1'b1, 1'b0, "carry_one_cycle");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000); expect_out(1, 16'h0000, 1'b0, 1'b0, "load_0000");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); expect_out(1, 16'h9999, 1'b1, 1'b1, "wrap_under");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); expect_out(1, 16'h9998, 1'b1, 1'b0, "after_under");

    // Saturation
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h9999); expect_out(2, 16'h9999, 1'b0, 1'b0, "sat_load_9999");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(2, 16'h9999, 1'b1, 1'b1, "sat_over1");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(2, 16'h9999, 1'b1, 1'b1, "sat_over2");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001); expect_out(2, 16'h0001, 1'b0, 1'b0, "sat_load_0001");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); expect_out(2, 16'h0000, 1'b1, 1'b0, "sat_reach_0");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); expect_out(2, 16'h0000, 1'b1, 1'b1, "sat_under1");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); expect_out(2, 16'h0000, 1'b1, 1'b1, "sat_under2");

    // Load on a prescaler-terminal cycle wins over the step
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h0000, 1'b0, 1'b0, "reset_again");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234); expect_out(0, 16'h1234, 1'b0, 1'b0, "load_priority");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h1234, 1'b0, 1'b0, "post_load1");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h1234, 1'b0, 1'b0, "post_load2");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h1235, 1'b1, 1'b0, "post_load3");

    // Enable gating keeps the prescaler phase
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h1235, 1'b0, 1'b0, "gate_pre1");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h1235, 1'b0, 1'b0, "gate_pre2");
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      expect_out(0, 16'h1235, 1'b0, 1'b0, "gate_frozen");
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h1236, 1'b1, 1'b0, "gate_resume");

    // Reset mid-run discards the prescaler phase
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0457); expect_out(0, 16'h0457, 1'b0, 1'b0, "load_0457");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h0457, 1'b0, 1'b0, "presc_at_1");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h0000, 1'b0, 1'b0, "reset_mid");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h0000, 1'b0, 1'b0, "after_rst1");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h0000, 1'b0, 1'b0, "after_rst2");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); expect_out(0, 16'h0001, 1'b1, 1'b0, "after_rst3");

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 4 && q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with a built-in clock prescaler, synchronous load, enable gating, and selectable wrap or saturate behaviour at the range limits. It replaces single-purpose binary counters wherever a display or timing path needs decimal digits directly. Examples are seven-segment drivers and pulse/event tallies. It emits one-cycle `tick` and `carry` pulses so that several instances can be chained or can trigger downstream logic.

## Interface
- `DIGITS`, default 4: number of BCD digits, range 1..8.
- `CLOCKS_PER_TICK`, default 1: enabled clock cycles per count step, range 1..(2**31-1).
- `WRAP`, default 1: limit behaviour. 1 = wrap around at the limits; 0 = saturate at the limits.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `en` input, 1 bit: enables the prescaler and counting. When low, the prescaler and `count` hold.
- `up` input, 1 bit: direction. 1 = increment, 0 = decrement. Sampled only on step cycles.
- `load` input, 1 bit: synchronous load request.
- `load_value` input, 4*DIGITS bits: BCD value to load. Digit 0 is in bits [3:0].
- `count` output, 4*DIGITS bits: current BCD value, registered.
- `tick` output, 1 bit: registered one-cycle pulse on every step taken.
- `carry` output, 1 bit: registered one-cycle pulse on overflow or underflow of the whole counter.

## Operation
- Priority per cycle: `rst` first, then `load`, then step.
- Reset: `count`=0, `tick`=0, `carry`=0, prescaler=0.
- Load:
  - `count` takes `load_value`. Any digit greater than 9 (0xA–0xF) is clamped to 9.
  - The prescaler is cleared to 0.
  - `tick` and `carry` are 0 in the following cycle.
  - `load` works regardless of `en`.
- Prescaler behaviour when `en`=1 and `load`=0:
  - If prescaler == CLOCKS_PER_TICK-1, this is a step cycle. The prescaler goes to 0.
  - Otherwise the prescaler increments.
- Step up:
  - Digit 0 is incremented.
  - Each digit rolls over 9 to 0 and generates a carry into the next digit (ripple).
  - From the all-9s value: if WRAP=1, `count` becomes all-0s; if WRAP=0, `count` holds at all-9s. In both cases `carry` pulses.
- Step down:
  - Each digit rolls over 0 to 9 and generates a borrow into the next digit.
  - From all-0s: if WRAP=1, `count` becomes all-9s; if WRAP=0, `count` holds at all-0s. In both cases `carry` pulses.
- `tick` pulses on every step cycle, including saturated steps where `count` does not change.
- When `en`=0, prescaler state is retained. Counting resumes from the retained phase when `en` returns to 1.
- A change of `up` between steps has no effect until the next step cycle.

## Timing
- `count`, `tick` and `carry` all change on the same clock edge. The pulses coincide with the cycle in which the new `count` is visible.
- Load latency: 1 cycle from `load` being sampled to `load_value` appearing on `count`.
- First step: occurs on the CLOCKS_PER_TICK-th enabled edge after reset or load. With CLOCKS_PER_TICK=1, the counter steps on every enabled cycle and `tick` stays high continuously.
- Reset mid-operation: all outputs read 0 in the cycle after `rst` is sampled. Any pending prescaler phase is discarded.
- `load` and a step cycle in the same cycle: the load wins. No step is taken and no pulse is emitted.
- The ripple carry across all DIGITS digits is combinational within one cycle. The counter is specified for DIGITS ≤ 8 at the target clock.

## Structure
- Package `bcd_pkg`:
  - `typedef logic [3:0] bcd_digit_t`.
  - Constants `BCD_MIN`=4'd0 and `BCD_MAX`=4'd9.
  - Function `bcd_clamp()`, which maps a nibble greater than 9 to 9.
- Sub-module `bcd_digit`:
  - One digit register with `step`, `up`, `cin` (carry/borrow in) and `load` inputs.
  - Outputs `value` and `cout`. `cout` is combinational: high when the digit is at its limit for the current direction and `cin` is high.
  - The top level instantiates DIGITS copies in a generate loop. It also contains the prescaler, the saturation check, and the `tick`/`carry` registers.

## Test plan
All scenarios use DIGITS=4, CLOCKS_PER_TICK=3 and WRAP=1 unless stated otherwise.
- **Reset and prescaler.** Apply reset, then hold `en`=1 and `up`=1. `count` must read 0x0000 after reset. `tick` must pulse on the 3rd, 6th and 9th enabled edges, with `count` reading 0x0001, 0x0002 and 0x0003 respectively.
- **Cascade, up and down** (CLOCKS_PER_TICK=1).
  - Load 0x0099, count up: next value 0x0100, `carry`=0.
  - Load 0x0100, count down: next value 0x0099.
  - Load 0x00AF: `count` must read 0x0099 (clamping).
- **Overflow and underflow.**
  - Load 0x9999, count up: `count` becomes 0x0000 with `carry`=1 for one cycle.
  - Load 0x0000, count down: `count` becomes 0x9999 with `carry`=1.
  - Repeat both with WRAP=0: `count` holds at 0x9999 or 0x0000, with `tick`=1 and `carry`=1 on each step.
- **Load priority.** Assert `load` with `load_value`=0x1234 on a prescaler-terminal cycle. `count` must read 0x1234 with `tick`=0 and `carry`=0. The next step must occur exactly 3 enabled edges later, giving 0x1235.
- **Enable gating.** Drop `en` after 2 enabled edges and hold it low for 5 cycles. `count` and `tick` must stay frozen. After `en` returns high, a step must occur on the first enabled edge.
- **Reset mid-run.** Assert `rst` while `count`=0x0457 and the prescaler is at 1. The next cycle must show `count`=0x0000. The first step after reset must follow 3 enabled edges.
